uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Byte FIFO between the CPU/bus write side and the UART transmitter.
//   Accepts bytes at bus rate and buffers them.
//   Drains them one at a time into the transmitter using its start/busy handshake.
//   Provides full/empty/level status and a sticky overflow flag for the bus interface.
// PARAMETERS
//   DEPTH_LOG2   4   log2 of FIFO depth (default 16 entries)
//   HI_TIMEOUT   3   cycles to wait for tx_busy to rise after a start strobe
// PORTS
//   clk           in   1             system clock; all logic on rising edge
//   rst           in   1             asynchronous reset, active-low
//   wr_en         in   1             push wr_data this cycle
//   wr_data       in   8             byte to enqueue
//   clr_overflow  in   1             clear the overflow flag
//   full          out  1             FIFO holds 2**DEPTH_LOG2 bytes
//   empty         out  1             FIFO holds 0 bytes
//   count         out  DEPTH_LOG2+1  bytes currently stored; excludes the byte in flight
//   overflow      out  1             sticky: a push was dropped because the FIFO was full
//   tx_data       out  8             byte presented to the transmitter
//   tx_start_n    out  1             active-low one-cycle start strobe to the transmitter
//   tx_busy       in   1             transmitter busy; high while shifting a byte
// BEHAVIOUR
//   Reset (rst=0, async)
//     - rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=0
//     - tx_data=8'h00, tx_start_n=1, FSM=IDLE
//     - Reset mid-transfer flushes all buffered bytes.
//     - The transmitter's in-progress byte is not affected by this block.
//   Storage
//     - Circular buffer of 2**DEPTH_LOG2 x 8 bits.
//     - wr_ptr and rd_ptr are DEPTH_LOG2+1 bits wide and wrap modulo 2**(DEPTH_LOG2+1).
//     - count = wr_ptr - rd_ptr (modulo arithmetic).
//     - full when count == 2**DEPTH_LOG2; empty when count == 0.
//     - full, empty and count are registered and consistent with each other in every cycle.
//   Push
//     - On the edge where wr_en=1 and full=0 (values before the edge): mem[wr_ptr]<=wr_data, wr_ptr++.
//     - If wr_en=1 and full=1: the byte is dropped and overflow<=1.
//     - A pop on the same edge does not make room for that push.
//     - If clr_overflow=1 on the same edge as a dropped push, set wins: overflow stays 1.
//   Pop FSM (all outputs registered)
//     - IDLE: if empty=0 and tx_busy=0:
//         tx_data<=mem[rd_ptr], rd_ptr++, tx_start_n<=0, go to START.
//     - START: tx_start_n<=1, timer<=0, go to WAIT_HI. The strobe is exactly one cycle low.
//     - WAIT_HI: if tx_busy=1, go to WAIT_LO.
//         Otherwise timer++. When timer reaches HI_TIMEOUT, go to IDLE
//         (a transmitter that finishes quickly is treated as done).
//     - WAIT_LO: when tx_busy=0, go to IDLE.
//     - tx_data is held stable from START until the FSM next leaves IDLE.
//   Simultaneous push and pop on one edge
//     - Both take effect and count is unchanged.
//     - Allowed even when count==1; the new byte is then the next one sent.
//   Latency
//     - Empty FIFO, IDLE, tx_busy=0, push sampled at edge E:
//       empty=0 after E; tx_start_n is low for the cycle between edges E+1 and E+2.
//   Throughput
//     - One byte per transmitter frame.
//     - Back-to-back bytes are separated by at least one IDLE cycle after tx_busy falls.
// TESTING
//   1. Reset mid-drain: push 5 bytes, assert rst=0 during WAIT_LO
//      -> empty=1, count=0, tx_start_n=1 immediately. No further strobes after release.
//   2. Single byte: push 8'hA5 into an idle FIFO with busy modelled at 10 cycles
//      -> tx_start_n low exactly 1 cycle at E+1..E+2, tx_data=8'hA5, count returns to 0.
//   3. Fill and overflow (DEPTH_LOG2=4), transmitter held busy: push 17 bytes 0x00..0x10
//      -> full=1 after the 16th push, overflow=1, byte 0x10 not sent.
//      Drain order is 0x00..0x0F.
//   4. Overflow vs clear: push while full and assert clr_overflow on the same edge
//      -> overflow=1. Next edge with clr_overflow=1 only -> overflow=0.
//   5. Pointer wrap: 40 pushes interleaved with drains using a transmitter model
//      -> bytes out equal bytes in, in order, and count never exceeds 16.
//   6. Busy never rises: tx_busy tied 0, push 2 bytes
//      -> each strobe is followed by HI_TIMEOUT wait cycles, then the next strobe. Both bytes are presented.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO sitting between the bus write side and a UART transmitter.
//   Bytes are accepted at bus rate, buffered in a circular store and drained
//   one at a time into the transmitter through its start/busy handshake.
//
// Parameters
//   DEPTH_LOG2    log2 of the FIFO depth (default 16 entries)
//   HI_TIMEOUT    cycles to wait for tx_busy to rise after a start strobe
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-low; flushes all buffered bytes
//   wr_en         push wr_data this cycle
//   wr_data       byte to enqueue
//   clr_overflow  clear the sticky overflow flag
//   full          FIFO holds 2**DEPTH_LOG2 bytes
//   empty         FIFO holds no bytes
//   count         bytes stored, excluding the byte already handed to the TX
//   overflow      sticky: a push was dropped because the FIFO was full
//   tx_data       byte presented to the transmitter
//   tx_start_n    active-low one-cycle start strobe to the transmitter
//   tx_busy       transmitter busy, high while shifting a byte
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned HI_TIMEOUT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  clr_overflow,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_start_n,
  input  logic                  tx_busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TW    = $clog2(HI_TIMEOUT + 2);

  // Last timer value spent in WAIT_HI before giving up on tx_busy.
  localparam logic [TW-1:0] TIMER_LAST =
    (HI_TIMEOUT == 0) ? '0 : TW'(HI_TIMEOUT - 1);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_e;

  logic [7:0]          mem_q [DEPTH];

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q,  count_d;
  logic                full_q,   full_d;
  logic                empty_q,  empty_d;
  logic                overflow_q, overflow_d;

  state_e              state_q;
  logic [7:0]          tx_data_q;
  logic                tx_start_n_q;
  logic [TW-1:0]       timer_q;

  logic                push;
  logic                drop;
  logic                pop;

  // Push/pop decisions use the registered flags only, so a pop on the same
  // edge never frees a slot for a push to a full FIFO.
  always_comb begin
    push       = wr_en && !full_q;
    drop       = wr_en &&  full_q;
    pop        = (state_q == S_IDLE) && !empty_q && !tx_busy;

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Status is derived from next-state pointers so count/full/empty are
    // always registered together and mutually consistent.
    count_d    = wr_ptr_d - rd_ptr_d;
    empty_d    = (count_d == '0);
    full_d     = (count_d == FULL_COUNT);

    // A dropped push takes priority over a clear on the same edge.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      state_q      <= S_IDLE;
      tx_data_q    <= '0;
      tx_start_n_q <= 1'b1;
      timer_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_data_q    <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            tx_start_n_q <= 1'b0;
            state_q      <= S_START;
          end
        end

        S_START: begin
          tx_start_n_q <= 1'b1;
          timer_q      <= '0;
          state_q      <= S_WAIT_HI;
        end

        // A transmitter that never raises busy within the window is
        // treated as having already finished the byte.
        S_WAIT_HI: begin
          if (tx_busy) begin
            state_q <= S_WAIT_LO;
          end else if (timer_q >= TIMER_LAST) begin
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_WAIT_LO: begin
          if (!tx_busy) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign tx_data    = tx_data_q;
  assign tx_start_n = tx_start_n_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. Stimulus pushes the bytes it
//   expects to see transmitted into exp_q; an independent monitor pops and
//   compares on every start strobe. A small transmitter model drives tx_busy.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int unsigned DL2   = 4;
  localparam int unsigned HIT   = 3;
  localparam int unsigned DEPTH = 16;

  logic        clk          = 1'b0;
  logic        rst          = 1'b0;
  logic        wr_en        = 1'b0;
  logic [7:0]  wr_data      = 8'h00;
  logic        clr_overflow = 1'b0;
  logic        tx_busy      = 1'b0;

  logic        full;
  logic        empty;
  logic [DL2:0] count;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_start_n;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q [$];

  // Transmitter model: 0 = busy for busy_len cycles per strobe,
  // 1 = busy tied low, 2 = busy held high.
  int          busy_mode = 0;
  int          busy_len  = 10;
  int          busy_cnt  = 0;
  logic        prev_low  = 1'b0;

  uart_tx_fifo #(
    .DEPTH_LOG2 (DL2),
    .HI_TIMEOUT (HIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_data      (tx_data),
    .tx_start_n   (tx_start_n),
    .tx_busy      (tx_busy)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Transmitter model
  initial forever begin
    @(negedge clk);
    if (busy_mode == 1) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end else if (busy_mode == 2) begin
      tx_busy  = 1'b1;
      busy_cnt = 0;
    end else if (rst && !tx_start_n) begin
      tx_busy  = 1'b1;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end else begin
      tx_busy = 1'b0;
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_low = 1'b0;
    end else begin
      if (!tx_start_n) begin
        check("strobe_width_prev_low", 32'(prev_low), 32'(0));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got tx_data %0h required no strobe", tx_data);
        end else begin
          check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      prev_low = !tx_start_n;
      check("status_consistency", 32'({empty, full}),
            32'({count == 0, count == DEPTH}));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached required completion");
    $fatal(1, "watchdog");
  end

  // Assumes the caller is at a negedge; consecutive calls push back-to-back.
  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && empty && tx_start_n && !tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: got timeout after %0d cycles (%0d bytes pending) required drained",
               name, n, exp_q.size());
    end
    repeat (HIT + 4) @(negedge clk);
  endtask

  int strobe_k [$];

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count",      32'(count),      32'(0));
    check("rst_empty",      32'(empty),      32'(1));
    check("rst_full",       32'(full),       32'(0));
    check("rst_overflow",   32'(overflow),   32'(0));
    check("rst_tx_data",    32'(tx_data),    32'(8'h00));
    check("rst_tx_start_n", 32'(tx_start_n), 32'(1));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte latency
    busy_mode = 0;
    busy_len  = 10;
    exp_q.push_back(8'hA5);
    push(8'hA5);
    check("lat_empty_after_E",  32'(empty),      32'(0));
    check("lat_count_after_E",  32'(count),      32'(1));
    check("lat_strobe_not_yet", 32'(tx_start_n), 32'(1));
    @(negedge clk);
    check("lat_strobe_low",     32'(tx_start_n), 32'(0));
    check("lat_tx_data",        32'(tx_data),    32'(8'hA5));
    check("lat_count_popped",   32'(count),      32'(0));
    @(negedge clk);
    check("lat_strobe_one_cyc", 32'(tx_start_n), 32'(1));
    check("lat_tx_data_held",   32'(tx_data),    32'(8'hA5));
    wait_idle(200, "single_byte_drain");
    check("single_count_end",   32'(count),      32'(0));

    // Reset mid-drain
    exp_q.push_back(8'h11);
    for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
    check("middrain_count",     32'(count),      32'(4));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("middrain_rst_empty",  32'(empty),      32'(1));
    check("middrain_rst_count",  32'(count),      32'(0));
    check("middrain_rst_strobe", 32'(tx_start_n), 32'(1));
    check("middrain_rst_full",   32'(full),       32'(0));
    check("middrain_sent_first", 32'(exp_q.size()), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("middrain_post_empty", 32'(empty),      32'(1));
    check("middrain_post_count", 32'(count),      32'(0));

    // Fill and overflow with transmitter held busy
    busy_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      push(8'(i));
    end
    check("fill_full",      32'(full),     32'(1));
    check("fill_count",     32'(count),    32'(16));
    check("fill_empty",     32'(empty),    32'(0));
    check("fill_no_ovf",    32'(overflow), 32'(0));
    push(8'h10);
    check("ovf_set",        32'(overflow), 32'(1));
    check("ovf_count_held", 32'(count),    32'(16));

    // Overflow vs clear
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared",    32'(overflow), 32'(0));
    wr_en        = 1'b1;
    wr_data      = 8'h77;
    clr_overflow = 1'b1;
    @(negedge clk);
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    check("ovf_set_wins",   32'(overflow), 32'(1));
    check("ovf_count_same", 32'(count),    32'(16));
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_clear_only", 32'(overflow), 32'(0));

    busy_mode = 0;
    busy_len  = 4;
    wait_idle(2000, "fill_drain");
    check("fill_drain_count", 32'(count), 32'(0));
    check("fill_drain_empty", 32'(empty), 32'(1));

    // Pointer wrap with interleaved drains
    busy_len = 3;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(i * 37 + 5));
      push(8'(i * 37 + 5));
      if ((i % 4) == 3) repeat (30) @(negedge clk);
    end
    wait_idle(2000, "wrap_drain");
    check("wrap_no_overflow", 32'(overflow), 32'(0));
    check("wrap_count_end",   32'(count),    32'(0));

    // Busy never rises
    busy_mode = 1;
    @(negedge clk);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    push(8'h5A);
    push(8'hC3);
    check("nobusy_simul_count", 32'(count), 32'(1));
    for (int k = 0; k < 20; k++) begin
      if (!tx_start_n) strobe_k.push_back(k);
      @(negedge clk);
    end
    check("nobusy_strobes", 32'(strobe_k.size()), 32'(2));
    if (strobe_k.size() == 2)
      check("nobusy_gap", 32'(strobe_k[1] - strobe_k[0]), 32'(HIT + 2));
    wait_idle(200, "nobusy_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
